// File: rtl/idli_sqi_mem.sv
// SQI serial-SRAM responder: decodes READ/WRITE nibble streams into a DEPTH-byte array; RDMR/WRMR only with IDLI_SQI_MEM_MODE_EN.
// Outputs are registered, so read nibble m is launched on edge m-1. There is no backpressure, and CS high aborts any phase.
module idli_sqi_mem #(
    parameter int DEPTH = 256
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sqi_cs,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_sio_en
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
`ifdef IDLI_SQI_MEM_MODE_EN
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
`endif

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_MODE_RD,
        ST_MODE_WR,
        ST_IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_hi_q, cmd_hi_d;
    logic          is_read_q, is_read_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    nib_q, nib_d;
    logic          lo_q, lo_d;
    logic [3:0]    sio_q, sio_d;
    logic          sio_en_q, sio_en_d;
    logic [7:0]    mem_q [DEPTH];

    logic          mem_we;
    logic [7:0]    mem_wdat;
    logic [7:0]    rd_byte;
    logic [1:0]    mode_sel;
    logic          page_mode;
    logic          byte_mode;
    logic [AW-1:0] addr_seq;
    logic [AW-1:0] addr_inc;

`ifdef IDLI_SQI_MEM_MODE_EN
    logic [7:0]    mode_q, mode_d;
    assign mode_sel = mode_q[7:6];
`else
    assign mode_sel = 2'b01;
`endif

    // Page mode keeps the upper address bits and wraps the low five within a 32-byte page.
    assign page_mode = (mode_sel == 2'b10);
    assign byte_mode = (mode_sel == 2'b00);
    assign addr_seq  = addr_q + AW'(1);
    assign addr_inc  = page_mode ? ((addr_q & ~AW'(31)) | (addr_seq & AW'(31))) : addr_seq;
    assign rd_byte   = mem_q[addr_q];
    assign mem_wdat  = {nib_q, i_sqi_sio};

    assign o_sqi_sio    = sio_q;
    assign o_sqi_sio_en = sio_en_q;

    always_comb begin
        state_d   = state_q;
        cmd_hi_d  = cmd_hi_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        nib_d     = nib_q;
        lo_d      = lo_q;
        sio_d     = 4'h0;
        sio_en_d  = 1'b0;
        mem_we    = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
        mode_d    = mode_q;
`endif
        if (i_sqi_cs) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            lo_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_hi_d = i_sqi_sio;
                    state_d  = ST_CMD;
                end
                ST_CMD: begin
                    cnt_d = 3'd0;
                    lo_d  = 1'b0;
                    case ({cmd_hi_q, i_sqi_sio})
                        CMD_READ: begin
                            is_read_d = 1'b1;
                            state_d   = ST_ADDR;
                        end
                        CMD_WRITE: begin
                            is_read_d = 1'b0;
                            state_d   = ST_ADDR;
                        end
`ifdef IDLI_SQI_MEM_MODE_EN
                        CMD_RDMR: begin
                            state_d  = ST_MODE_RD;
                            sio_d    = mode_q[7:4];
                            sio_en_d = 1'b1;
                            lo_d     = 1'b1;
                        end
                        CMD_WRMR: state_d = ST_MODE_WR;
`endif
                        default: state_d = ST_IGNORE;
                    endcase
                end
                ST_ADDR: begin
                    // Only the low AW bits survive the 24-bit shift.
                    addr_d = {addr_q[AW-5:0], i_sqi_sio};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d   = 3'd0;
                        state_d = is_read_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d  = ST_RDATA;
                        sio_d    = rd_byte[7:4];
                        sio_en_d = 1'b1;
                        lo_d     = 1'b1;
                    end
                end
                ST_RDATA: begin
                    sio_en_d = 1'b1;
                    lo_d     = ~lo_q;
                    if (lo_q) begin
                        sio_d  = rd_byte[3:0];
                        addr_d = addr_inc;
                        if (byte_mode) begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        sio_d = rd_byte[7:4];
                    end
                end
                ST_WDATA: begin
                    lo_d = ~lo_q;
                    if (lo_q) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                        if (byte_mode) begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        nib_d = i_sqi_sio;
                    end
                end
`ifdef IDLI_SQI_MEM_MODE_EN
                ST_MODE_RD: begin
                    sio_en_d = 1'b1;
                    lo_d     = ~lo_q;
                    sio_d    = lo_q ? mode_q[3:0] : mode_q[7:4];
                end
                ST_MODE_WR: begin
                    lo_d = ~lo_q;
                    if (lo_q) begin
                        mode_d  = {nib_q, i_sqi_sio};
                        state_d = ST_IGNORE;
                    end else begin
                        nib_d = i_sqi_sio;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cmd_hi_q  <= 4'h0;
            is_read_q <= 1'b0;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            nib_q     <= 4'h0;
            lo_q      <= 1'b0;
            sio_q     <= 4'h0;
            sio_en_q  <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
            mode_q    <= 8'h40;
`endif
        end else begin
            state_q   <= state_d;
            cmd_hi_q  <= cmd_hi_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            nib_q     <= nib_d;
            lo_q      <= lo_d;
            sio_q     <= sio_d;
            sio_en_q  <= sio_en_d;
`ifdef IDLI_SQI_MEM_MODE_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed and randomized transactions for idli_sqi_mem, checked against a byte-array model.
// Mode-register steps are built only when IDLI_SQI_MEM_MODE_EN is defined.
module tb_idli_sqi_mem;
    localparam int DEPTH = 256;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic [3:0] sio;
    logic [3:0] o_sio;
    logic       o_en;

    idli_sqi_mem #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sqi_cs    (cs),
        .i_sqi_sio   (sio),
        .o_sqi_sio   (o_sio),
        .o_sqi_sio_en(o_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n_tests;
    int         n_failed;
    logic [3:0] tx      [0:599];
    int         tx_len;
    logic [3:0] rx_sio  [0:599];
    logic       rx_en   [0:599];
    logic [7:0] wbuf    [0:255];
    logic [7:0] rbuf    [0:255];
    logic [7:0] mdl_mem [DEPTH];
    logic [7:0] mdl_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Device address of data byte k of a transfer starting at a; -1 when not transferred.
    function automatic int map_addr(input int a, input int k);
        if (mdl_mode[7:6] == 2'b00) return (k == 0) ? a : -1;
        if (mdl_mode[7:6] == 2'b10) return (a & ~31) | ((a + k) & 31);
        return (a + k) % DEPTH;
    endfunction

    // Edges whose registered o_sqi_sio_en disagrees with "high exactly for edges lo..hi".
    function automatic int en_bad(input int lo, input int hi);
        int bad = 0;
        for (int e = 0; e < tx_len; e++) begin
            if (rx_en[e] !== ((e >= lo) && (e <= hi))) bad++;
        end
        return bad;
    endfunction

    task automatic build_hdr(input logic [7:0] cmd, input logic [23:0] a24);
        tx[0] = cmd[7:4];
        tx[1] = cmd[3:0];
        for (int i = 0; i < 6; i++) tx[2 + i] = a24[23 - 4 * i -: 4];
    endtask

    // Sends tx[0..tx_len-1] with CS low, recording outputs #1 after each edge, then one CS-high edge.
    task automatic run_txn(input string tag);
        for (int i = 0; i < tx_len; i++) begin
            @(negedge clk);
            cs  = 1'b0;
            sio = tx[i];
            @(posedge clk);
            #1;
            rx_sio[i] = o_sio;
            rx_en[i]  = o_en;
        end
        @(negedge clk);
        cs  = 1'b1;
        sio = 4'h0;
        @(posedge clk);
        #1;
        check({tag, "_cs_high_en"}, o_en, 1'b0);
    endtask

    task automatic do_write(input logic [23:0] a24, input int n, input bit partial, input string tag);
        int a;
        int ad;
        a = int'(a24) % DEPTH;
        build_hdr(8'h02, a24);
        for (int k = 0; k < n; k++) begin
            tx[8 + 2 * k] = wbuf[k][7:4];
            tx[9 + 2 * k] = wbuf[k][3:0];
        end
        tx_len = 8 + 2 * n;
        if (partial) begin
            tx[tx_len] = 4'($urandom);
            tx_len++;
        end
        run_txn(tag);
        check({tag, "_en_bad_edges"}, en_bad(tx_len, tx_len), 0);
        for (int k = 0; k < n; k++) begin
            ad = map_addr(a, k);
            if (ad >= 0) mdl_mem[ad] = wbuf[k];
        end
    endtask

    task automatic do_read(input logic [23:0] a24, input int n, input string tag);
        int a;
        int ad;
        a = int'(a24) % DEPTH;
        build_hdr(8'h03, a24);
        tx_len = 10 + 2 * n;
        for (int i = 8; i < tx_len; i++) tx[i] = 4'($urandom);
        run_txn(tag);
        if (mdl_mode[7:6] == 2'b00) check({tag, "_en_bad_edges"}, en_bad(9, 10), 0);
        else                        check({tag, "_en_bad_edges"}, en_bad(9, tx_len), 0);
        for (int k = 0; k < n; k++) begin
            rbuf[k] = {rx_sio[9 + 2 * k], rx_sio[10 + 2 * k]};
            ad = map_addr(a, k);
            if (ad >= 0) check($sformatf("%s_byte%0d", tag, k), rbuf[k], mdl_mem[ad]);
        end
    endtask

    task automatic do_ignore(input logic [7:0] cmd, input string tag);
        tx[0] = cmd[7:4];
        tx[1] = cmd[3:0];
        tx_len = 22;
        for (int i = 2; i < tx_len; i++) tx[i] = 4'($urandom);
        run_txn(tag);
        check({tag, "_en_bad_edges"}, en_bad(tx_len, tx_len), 0);
    endtask

`ifdef IDLI_SQI_MEM_MODE_EN
    task automatic do_wrmr(input logic [7:0] mv, input string tag);
        tx[0] = 4'h0;
        tx[1] = 4'h1;
        tx[2] = mv[7:4];
        tx[3] = mv[3:0];
        tx[4] = 4'($urandom);
        tx[5] = 4'($urandom);
        tx_len = 6;
        run_txn(tag);
        check({tag, "_en_bad_edges"}, en_bad(tx_len, tx_len), 0);
        mdl_mode = mv;
    endtask

    task automatic do_rdmr(input string tag);
        tx[0] = 4'h0;
        tx[1] = 4'h5;
        tx_len = 6;
        for (int i = 2; i < tx_len; i++) tx[i] = 4'($urandom);
        run_txn(tag);
        check({tag, "_en_bad_edges"}, en_bad(1, tx_len), 0);
        rbuf[0] = {rx_sio[1], rx_sio[2]};
        rbuf[1] = {rx_sio[3], rx_sio[4]};
        check({tag, "_mode0"}, rbuf[0], mdl_mode);
        check({tag, "_mode1"}, rbuf[1], mdl_mode);
    endtask
`endif

    initial begin
        logic [23:0] a24;
        logic [7:0]  mv;
        int          n;
        n_tests  = 0;
        n_failed = 0;
        mdl_mode = 8'h40;
        rst_n    = 1'b0;
        cs       = 1'b1;
        sio      = 4'h0;

        // Reset state.
        #12;
        check("reset_outputs", {o_en, o_sio}, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole array so every later read has a known model value.
        for (int k = 0; k < DEPTH; k++) wbuf[k] = 8'($urandom);
        do_write(24'h000000, DEPTH, 1'b0, "fill");

        // Basic write then read-back.
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        do_write(24'h000010, 2, 1'b0, "plan_wr");
        do_read(24'h000010, 2, "plan_rd");
        check("plan_rd_const", {rbuf[0], rbuf[1]}, 16'hA53C);

        // Sequential wrap at the top of the array.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(24'(DEPTH - 1), 2, 1'b0, "wrap_wr");
        do_read(24'h000000, 1, "wrap_rd0");
        check("wrap_rd0_const", rbuf[0], 8'h22);
        do_read(24'(DEPTH - 1), 2, "wrap_rdtop");
        check("wrap_rdtop_const", {rbuf[0], rbuf[1]}, 16'h1122);

        // Unknown command: no drive, array untouched.
        do_ignore(8'hFF, "ign_ff");
`ifndef IDLI_SQI_MEM_MODE_EN
        do_ignore(8'h05, "ign_rdmr");
        do_ignore(8'h01, "ign_wrmr");
`endif
        do_read(24'h000000, 32, "ign_readback");

        // Partial byte at CS rise is discarded.
        wbuf[0] = ~mdl_mem[5];
        do_write(24'h000005, 0, 1'b1, "partial_wr");
        do_read(24'h000005, 1, "partial_rd");

        // CS raised mid-address, then a fresh command decodes normally.
        build_hdr(8'h02, 24'h000010);
        tx_len = 5;
        run_txn("abort_addr");
        check("abort_addr_en_bad_edges", en_bad(tx_len, tx_len), 0);
        do_read(24'h000010, 2, "abort_rd");
        check("abort_rd_const", {rbuf[0], rbuf[1]}, 16'hA53C);

`ifdef IDLI_SQI_MEM_MODE_EN
        do_wrmr(8'hC0, "pre_rst_wrmr");
        do_rdmr("pre_rst_rdmr");
`endif
        // Async reset during read data; CS stays low so the following edges form a new transaction.
        build_hdr(8'h03, 24'h000010);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cs  = 1'b0;
            sio = (i < 8) ? tx[i] : 4'h0;
            @(posedge clk);
            #1;
        end
        check("rst_mid_pre_en", o_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {o_en, o_sio}, 5'h00);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mdl_mode = 8'h40;
        do_read(24'h000010, 2, "rst_rd");
        check("rst_rd_const", {rbuf[0], rbuf[1]}, 16'hA53C);
`ifdef IDLI_SQI_MEM_MODE_EN
        do_rdmr("post_rst_rdmr");
        check("post_rst_mode_const", rbuf[0], 8'h40);

        // Page mode: bytes 4..7 of a write from 0x1C wrap to 0x00..0x03.
        do_wrmr(8'h80, "page_wrmr");
        for (int k = 0; k < 8; k++) wbuf[k] = 8'(8'h60 + k);
        do_write(24'h00001C, 8, 1'b0, "page_wr");
        do_wrmr(8'h40, "seq_wrmr");
        do_read(24'h000000, 4, "page_rd_lo");
        check("page_rd_lo_const", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, 32'h64656667);
        do_read(24'h00001C, 4, "page_rd_hi");
        check("page_rd_hi_const", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, 32'h60616263);

        // Byte mode: one data byte, then the responder stops driving.
        do_wrmr(8'h00, "byte_wrmr");
        do_read(24'h000010, 2, "byte_rd");
        check("byte_rd_const", rbuf[0], 8'hA5);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 24; it++) begin
`ifdef IDLI_SQI_MEM_MODE_EN
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mv = 8'h00;
                    1:       mv = 8'h80;
                    2:       mv = 8'h40;
                    default: mv = 8'hC0;
                endcase
                do_wrmr(mv, "rnd_wrmr");
            end
`endif
            a24 = 24'($urandom);
            n   = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                do_write(a24, n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_wr", it));
                do_read(a24, n, $sformatf("rnd%0d_rb", it));
            end else begin
                do_read(a24, n, $sformatf("rnd%0d_rd", it));
            end
        end

`ifdef IDLI_SQI_MEM_MODE_EN
        do_wrmr(8'h40, "final_wrmr");
`endif
        do_read(24'h000000, DEPTH, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule

// File: doc/idli_sqi_mem.md
# idli_sqi_mem

Synthesisable SQI serial-SRAM responder: the device end of the SQI link driven by the core's memory controller. Two instances sit on the board/bench side, one per `sqi_mem_t` slot (`SQI_MEM_LO` holds low nibbles, `SQI_MEM_HI` high nibbles). Each instance decodes READ/WRITE commands arriving 4b per cycle, holds a byte array, and returns read data 4b per cycle, sequential-mode by default.

## Interface
Parameters:
- `DEPTH` — 256 — bytes of storage; power of two, 32..65536; address uses low `$clog2(DEPTH)` bits.

Ports:
- `i_clk` in 1 — SQI clock; the single clock for all state.
- `i_rst_n` in 1 — reset, asynchronous, active-low.
- `i_sqi_cs` in 1 — chip select, active-low.
- `i_sqi_sio` in `sqi_data_t` — data from controller, sampled on `i_clk` rise.
- `o_sqi_sio` out `sqi_data_t` — data to controller.
- `o_sqi_sio_en` out 1 — responder drives the SIO lines when high.

## Operation
- Transaction = run of consecutive rising edges with `i_sqi_cs` low; nibble index n counts from 0 at the first such edge. All multi-nibble fields MSB nibble first.
- n=0..1: command byte. n=2..7: 24b address; bits above `$clog2(DEPTH)` ignored.
- Commands: 0x03 READ, 0x02 WRITE; 0x05 RDMR and 0x01 WRMR only with macro (see Configuration); anything else → IGNORE.
- READ: n=8..9 dummy; data byte k occupies nibbles 10+2k (high) and 11+2k (low).
- WRITE: data byte k occupies nibbles 8+2k (high) and 9+2k (low); array written on the low nibble's edge. Partial byte at CS rise is discarded.
- Address advances by 1 after each complete byte; sequential mode wraps at `DEPTH-1 → 0`.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, MODE_RD, MODE_WR, IGNORE. IDLE→CMD on first CS-low edge; CMD→ADDR/MODE_*/IGNORE after n=1; ADDR→DUMMY (READ) or WDATA (WRITE) after n=7; DUMMY→RDATA after n=9. IGNORE holds until CS high.
- `i_sqi_cs` high at any edge → IDLE, n cleared, `o_sqi_sio_en` low at that edge, regardless of state.
- Read-after-write to the same address in one transaction not possible; across transactions returns new data.

## Timing
- Reset: state IDLE, `o_sqi_sio`=0, `o_sqi_sio_en`=0, mode register=0x40 (sequential). Array contents not reset.
- Outputs registered. Nibble for index m is driven in the cycle after edge m−1, i.e. `o_sqi_sio`/`o_sqi_sio_en` update on edge m−1; first read nibble updates on edge 9, first valid at edge 10.
- `o_sqi_sio_en` high only while driving READ/RDMR data; low throughout command, address, dummy, write phases and IGNORE.
- Async reset mid-transaction: immediate IDLE, outputs low; remaining CS-low edges of that transaction treated as a new transaction starting at n=0.

## Configuration
- `IDLI_SQI_MEM_MODE_EN` defined: mode register supported. WRMR (0x01): next byte (n=2..3) written to mode register, further nibbles ignored. RDMR (0x05): mode byte driven at n=2..3, repeated every byte while CS low. Mode bits [7:6]: 00 byte (one data byte, then IGNORE, `o_sqi_sio_en` low), 10 page (address low 5 bits wrap within 32-byte page), 01/11 sequential.
- Undefined: no mode register; always sequential; 0x01/0x05 → IGNORE.

## Test plan
- WRITE 0x02, addr 0x000010, data 0xA5 0x3C; then READ addr 0x10 → nibbles A,5,3,C with `o_sqi_sio_en` high from edge 9, low during n=0..9.
- Sequential wrap: WRITE 0x11,0x22 at `DEPTH-1`; READ at 0 → 0x22, READ at `DEPTH-1` → 0x11,0x22.
- Unknown command 0xFF followed by 20 nibbles → `o_sqi_sio_en` stays 0, array unchanged (read-back verifies).
- CS raised after high nibble of a write byte at addr 5 → addr 5 retains old value; CS raised mid-address → next transaction decodes fresh command correctly.
- `i_rst_n` pulsed during RDATA → outputs 0 immediately; mode reads back 0x40 (macro on).
- Macro on: WRMR 0x80, WRITE 8 bytes from addr 0x1C → bytes 4..7 land at 0x00..0x03; WRMR 0x00, READ 2 bytes → one byte returned then `o_sqi_sio_en` low.
